// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NTAPS  = 16;
    localparam int DEF_TW     = 16;
    localparam int DEF_CE_GAP = 16;

endpackage

// File: rtl/fir_seq_ctrl.sv
// Sequencer: loads NTAPS coefficients into the FIR, then feeds samples with one CE each.
// Latency: coef/sample handshake in cycle N -> o_tap_wr / o_ce (+data) in cycle N+1.
// Backpressure: o_coef_ready/o_sample_ready are Moore; sample ready drops for CE_GAP-1 cycles after each accept.
//
// Ports:
//   i_clk, i_reset (async, active low)
//   i_start (active low), i_abort (active high), i_nsamples (0 = run until abort)
//   i_coef_valid/i_coef/o_coef_ready     : host coefficient stream, tap 0 first
//   i_sample_valid/i_sample/o_sample_ready : sample stream
//   o_tap_wr/o_tap                        : FIR tap-write port
//   o_ce/o_sample                         : FIR clock enable with aligned sample
//   o_loaded, o_busy, o_done, o_sample_cnt : status
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NTAPS  = DEF_NTAPS,
    parameter int TW     = DEF_TW,
    parameter int CE_GAP = DEF_CE_GAP
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [15:0]   i_nsamples,
    input  logic          i_coef_valid,
    input  logic [TW-1:0] i_coef,
    output logic          o_coef_ready,
    input  logic          i_sample_valid,
    input  logic [TW-1:0] i_sample,
    output logic          o_sample_ready,
    output logic [TW-1:0] o_sample,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_ce,
    output logic          o_loaded,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_sample_cnt
);

    localparam int TIW = $clog2(NTAPS + 1);
    localparam int GW  = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;

    localparam logic [TIW-1:0] TAP_LAST   = TIW'(NTAPS - 1);
    localparam logic [GW-1:0]  GAP_RELOAD = GW'(CE_GAP - 1);

    state_t          state_q,   state_d;
    logic [TIW-1:0]  tap_idx_q, tap_idx_d;
    logic [GW-1:0]   gap_q,     gap_d;
    logic [15:0]     cnt_q,     cnt_d;
    logic [15:0]     nsamp_q,   nsamp_d;
    logic            loaded_q,  loaded_d;
    logic            tap_wr_q,  tap_wr_d;
    logic [TW-1:0]   tap_q,     tap_d;
    logic            ce_q,      ce_d;
    logic [TW-1:0]   sample_q,  sample_d;
    logic            done_q,    done_d;

    logic            coef_hs;
    logic            smp_hs;
    logic [15:0]     cnt_inc;

    // Ready flags depend only on registered state so the host never sees a
    // combinational path from its own valid.
    assign o_coef_ready   = (state_q == LOAD);
    assign o_sample_ready = (state_q == RUN) && (gap_q == '0);
    assign o_busy         = (state_q != IDLE);

    assign coef_hs = o_coef_ready && i_coef_valid;
    assign smp_hs  = o_sample_ready && i_sample_valid;
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        tap_idx_d = tap_idx_q;
        // Gap counter free-runs down to zero in every state.
        gap_d     = (gap_q != '0) ? gap_q - GW'(1) : '0;
        cnt_d     = cnt_q;
        nsamp_d   = nsamp_q;
        loaded_d  = loaded_q;
        tap_wr_d  = 1'b0;
        tap_d     = tap_q;
        ce_d      = 1'b0;
        sample_d  = sample_q;
        done_d    = 1'b0;

        if (i_abort) begin
            // Abort wins over start and over any handshake this cycle:
            // nothing new is written or enabled.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!i_start) begin
                        state_d   = LOAD;
                        nsamp_d   = i_nsamples;
                        tap_idx_d = '0;
                        loaded_d  = 1'b0;
                        cnt_d     = '0;
                        gap_d     = '0;
                    end
                end
                LOAD: begin
                    if (coef_hs) begin
                        tap_wr_d  = 1'b1;
                        tap_d     = i_coef;
                        tap_idx_d = tap_idx_q + TIW'(1);
                        if (tap_idx_q == TAP_LAST) begin
                            state_d  = RUN;
                            loaded_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (smp_hs) begin
                        sample_d = i_sample;
                        ce_d     = 1'b1;
                        gap_d    = GAP_RELOAD;
                        cnt_d    = cnt_inc;
                        // nsamples == 0 means free-run; the count just wraps.
                        if ((nsamp_q != 16'd0) && (cnt_inc == nsamp_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            tap_idx_q <= '0;
            gap_q     <= '0;
            cnt_q     <= '0;
            nsamp_q   <= '0;
            loaded_q  <= 1'b0;
            tap_wr_q  <= 1'b0;
            tap_q     <= '0;
            ce_q      <= 1'b0;
            sample_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_idx_q <= tap_idx_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            nsamp_q   <= nsamp_d;
            loaded_q  <= loaded_d;
            tap_wr_q  <= tap_wr_d;
            tap_q     <= tap_d;
            ce_q      <= ce_d;
            sample_q  <= sample_d;
            done_q    <= done_d;
        end
    end

    assign o_tap_wr     = tap_wr_q;
    assign o_tap        = tap_q;
    assign o_ce         = ce_q;
    assign o_sample     = sample_q;
    assign o_loaded     = loaded_q;
    assign o_done       = done_q;
    assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: one instance with CE_GAP=16 (scoreboarded) and one with CE_GAP=1.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_seq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_nsamples;
    logic        i_coef_valid;
    logic [15:0] i_coef;
    logic        i_sample_valid;
    logic [15:0] i_sample;

    logic        o_coef_ready, o_sample_ready, o_tap_wr, o_ce, o_loaded, o_busy, o_done;
    logic [15:0] o_sample, o_tap, o_sample_cnt;

    logic        o1_coef_ready, o1_sample_ready, o1_tap_wr, o1_ce, o1_loaded, o1_busy, o1_done;
    logic [15:0] o1_sample, o1_tap, o1_sample_cnt;

    fir_seq_ctrl #(.NTAPS(16), .TW(16), .CE_GAP(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_nsamples(i_nsamples), .i_coef_valid(i_coef_valid), .i_coef(i_coef),
        .o_coef_ready(o_coef_ready), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .o_sample_ready(o_sample_ready), .o_sample(o_sample), .o_tap_wr(o_tap_wr),
        .o_tap(o_tap), .o_ce(o_ce), .o_loaded(o_loaded), .o_busy(o_busy),
        .o_done(o_done), .o_sample_cnt(o_sample_cnt)
    );

    fir_seq_ctrl #(.NTAPS(16), .TW(16), .CE_GAP(1)) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_nsamples(i_nsamples), .i_coef_valid(i_coef_valid), .i_coef(i_coef),
        .o_coef_ready(o1_coef_ready), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
        .o_sample_ready(o1_sample_ready), .o_sample(o1_sample), .o_tap_wr(o1_tap_wr),
        .o_tap(o1_tap), .o_ce(o1_ce), .o_loaded(o1_loaded), .o_busy(o1_busy),
        .o_done(o1_done), .o_sample_cnt(o1_sample_cnt)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b1;
    logic [15:0] tap_q[$];
    logic [15:0] smp_q[$];
    int          tap_cyc[$];
    int          ce_cyc[$];
    logic [15:0] mon_exp;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Scoreboard monitor for the CE_GAP=16 instance, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (mon_en && i_reset) begin
            if (o_tap_wr) begin
                tap_cyc.push_back(cyc);
                n_cmp++;
                if (tap_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tap_unexpected: got o_tap_wr=1 o_tap=%h, want no tap write", o_tap);
                end else begin
                    mon_exp = tap_q.pop_front();
                    if (o_tap !== mon_exp) begin
                        n_err++;
                        $display("FAIL tap_value: got %h want %h", o_tap, mon_exp);
                    end
                end
            end
            if (o_ce) begin
                ce_cyc.push_back(cyc);
                n_cmp++;
                if (smp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ce_unexpected: got o_ce=1 o_sample=%h, want no ce", o_sample);
                end else begin
                    mon_exp = smp_q.pop_front();
                    if (o_sample !== mon_exp) begin
                        n_err++;
                        $display("FAIL sample_value: got %h want %h", o_sample, mon_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Streams 16 coefficients back to back; optionally records them as expected taps.
    task automatic load_coefs(input bit push, input logic [15:0] base);
        for (int k = 1; k <= 16; k++) begin
            i_coef_valid = 1'b1;
            i_coef       = base + 16'(k);
            if (push && o_coef_ready) tap_q.push_back(i_coef);
            step();
        end
        i_coef_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_start = 1'b1; i_abort = 1'b0; i_nsamples = 16'd0;
        i_coef_valid = 1'b0; i_coef = 16'd0; i_sample_valid = 1'b0; i_sample = 16'd0;
        #2;
        n_cmp++;
        if ({o_coef_ready, o_sample_ready, o_tap_wr, o_ce, o_loaded, o_busy, o_done} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {o_coef_ready, o_sample_ready, o_tap_wr, o_ce, o_loaded, o_busy, o_done});
        end
        n_cmp++;
        if ({o_sample, o_tap, o_sample_cnt} !== 48'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {o_sample, o_tap, o_sample_cnt});
        end
        n_cmp++;
        if ({o1_coef_ready, o1_sample_ready, o1_tap_wr, o1_ce, o1_loaded, o1_busy, o1_done,
             o1_sample, o1_tap, o1_sample_cnt} !== 55'd0) begin
            n_err++;
            $display("FAIL reset_dut1: got %h want 0", {o1_coef_ready, o1_sample_ready, o1_tap_wr,
                     o1_ce, o1_loaded, o1_busy, o1_done, o1_sample, o1_tap, o1_sample_cnt});
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_load();
        i_nsamples = 16'd4;
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        n_cmp++;
        if ({o_busy, o_coef_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL start_busy: got busy,ready=%b want 11", {o_busy, o_coef_ready});
        end
        tap_cyc.delete();
        for (int k = 1; k <= 16; k++) begin
            i_coef_valid = 1'b1;
            i_coef       = 16'(k);
            if (o_coef_ready) tap_q.push_back(i_coef);
            step();
            if (k == 15) begin
                n_cmp++;
                if (o_loaded !== 1'b0) begin
                    n_err++;
                    $display("FAIL loaded_early: got %b want 0", o_loaded);
                end
            end
        end
        i_coef_valid = 1'b0;
        n_cmp++;
        if ({o_loaded, o_sample_ready, o_coef_ready} !== 3'b110) begin
            n_err++;
            $display("FAIL loaded_run: got loaded,sready,cready=%b want 110",
                     {o_loaded, o_sample_ready, o_coef_ready});
        end
        @(negedge i_clk);
        #1;
        n_cmp++;
        if (tap_cyc.size() != 16 || tap_q.size() != 0) begin
            n_err++;
            $display("FAIL tap_count: got %0d writes (%0d pending) want 16", tap_cyc.size(), tap_q.size());
        end else begin
            n_cmp++;
            if (tap_cyc[15] - tap_cyc[0] != 15) begin
                n_err++;
                $display("FAIL tap_consecutive: got span %0d want 15", tap_cyc[15] - tap_cyc[0]);
            end
        end
    endtask

    task automatic test_run_gap();
        int acc = 0;
        ce_cyc.delete();
        i_sample_valid = 1'b1;
        i_sample       = 16'hA001;
        for (int c = 0; c < 200 && acc < 4; c++) begin
            if (o_sample_ready) begin
                smp_q.push_back(i_sample);
                acc++;
            end
            step();
            i_sample = 16'hA001 + 16'(acc);
        end
        n_cmp++;
        if (acc != 4) begin
            n_err++;
            $display("FAIL run_timeout: got %0d accepts want 4", acc);
        end
        n_cmp++;
        if ({o_ce, o_done, o_loaded} !== 3'b111 || o_sample_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL run_done: got ce,done,loaded=%b cnt=%0d want 111 cnt=4",
                     {o_ce, o_done, o_loaded}, o_sample_cnt);
        end
        step();
        n_cmp++;
        if ({o_done, o_busy, o_sample_ready, o_ce} !== 4'b0000) begin
            n_err++;
            $display("FAIL run_idle: got done,busy,sready,ce=%b want 0000",
                     {o_done, o_busy, o_sample_ready, o_ce});
        end
        i_sample_valid = 1'b0;
        n_cmp++;
        if (ce_cyc.size() != 4 || smp_q.size() != 0) begin
            n_err++;
            $display("FAIL ce_count: got %0d ce (%0d pending) want 4", ce_cyc.size(), smp_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (ce_cyc[i] - ce_cyc[i-1] != 16) begin
                    n_err++;
                    $display("FAIL ce_gap: got %0d cycles want 16", ce_cyc[i] - ce_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_abort_load();
        i_nsamples = 16'd4;
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            i_coef_valid = 1'b1;
            i_coef       = 16'h0100 + 16'(k);
            if (o_coef_ready) tap_q.push_back(i_coef);
            step();
        end
        i_coef = 16'h01FF;
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        n_cmp++;
        if ({o_busy, o_loaded, o_coef_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_load: got busy,loaded,cready=%b want 000", {o_busy, o_loaded, o_coef_ready});
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (o_tap_wr !== 1'b0) begin
                n_err++;
                $display("FAIL abort_tap_wr: got %b want 0", o_tap_wr);
            end
            step();
        end
        i_coef_valid = 1'b0;
        n_cmp++;
        if (tap_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_taps_pending: got %0d want 0", tap_q.size());
        end
        i_start = 1'b0;
        i_abort = 1'b1;
        step();
        i_start = 1'b1;
        i_abort = 1'b0;
        n_cmp++;
        if ({o_busy, o_coef_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL start_abort_idle: got busy,cready=%b want 00", {o_busy, o_coef_ready});
        end
    endtask

    task automatic test_continuous();
        logic [15:0] prev;
        mon_en = 1'b0;
        i_nsamples = 16'd0;
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        load_coefs(1'b0, 16'h0200);
        i_sample_valid = 1'b1;
        i_sample       = 16'hC000;
        for (int k = 0; k < 40; k++) begin
            prev = i_sample;
            step();
            i_sample = prev + 16'd1;
            n_cmp++;
            if ({o1_ce, o1_done} !== 2'b10) begin
                n_err++;
                $display("FAIL cont_ce: cycle %0d got ce,done=%b want 10", k, {o1_ce, o1_done});
            end
            n_cmp++;
            if (o1_sample !== prev || o1_sample_cnt !== 16'(k + 1)) begin
                n_err++;
                $display("FAIL cont_sample: cycle %0d got %h cnt=%0d want %h cnt=%0d",
                         k, o1_sample, o1_sample_cnt, prev, k + 1);
            end
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        i_sample_valid = 1'b0;
        n_cmp++;
        if ({o1_busy, o1_ce, o1_done} !== 3'b000) begin
            n_err++;
            $display("FAIL cont_abort: got busy,ce,done=%b want 000", {o1_busy, o1_ce, o1_done});
        end
        step();
        tap_q.delete();
        smp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_start_held();
        int acc = 0;
        i_nsamples = 16'd2;
        i_start = 1'b0;
        step();
        load_coefs(1'b1, 16'h0300);
        n_cmp++;
        if ({o_busy, o_coef_ready, o_loaded} !== 3'b101) begin
            n_err++;
            $display("FAIL held_no_reload: got busy,cready,loaded=%b want 101", {o_busy, o_coef_ready, o_loaded});
        end
        i_sample_valid = 1'b1;
        i_sample       = 16'hB001;
        for (int c = 0; c < 100 && acc < 2; c++) begin
            if (o_sample_ready) begin
                smp_q.push_back(i_sample);
                acc++;
            end
            step();
            i_sample = 16'hB001 + 16'(acc);
        end
        n_cmp++;
        if ({o_done, o_loaded} !== 2'b11 || o_sample_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL held_done: got done,loaded=%b cnt=%0d want 11 cnt=2", {o_done, o_loaded}, o_sample_cnt);
        end
        step();
        n_cmp++;
        if ({o_busy, o_loaded} !== 2'b01) begin
            n_err++;
            $display("FAIL held_idle: got busy,loaded=%b want 01", {o_busy, o_loaded});
        end
        step();
        n_cmp++;
        if ({o_busy, o_coef_ready, o_loaded} !== 3'b110) begin
            n_err++;
            $display("FAIL held_reload: got busy,cready,loaded=%b want 110", {o_busy, o_coef_ready, o_loaded});
        end
        i_start = 1'b1;
        i_abort = 1'b1;
        i_sample_valid = 1'b0;
        step();
        i_abort = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        i_nsamples = 16'd0;
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        load_coefs(1'b1, 16'h0400);
        i_sample_valid = 1'b1;
        i_sample       = 16'hD00D;
        if (o_sample_ready) smp_q.push_back(i_sample);
        step();
        i_sample_valid = 1'b0;
        @(negedge i_clk);
        #2;
        i_reset = 1'b0;
        #1;
        n_cmp++;
        if ({o_coef_ready, o_sample_ready, o_tap_wr, o_ce, o_loaded, o_busy, o_done} !== 7'd0 ||
            {o_sample, o_tap, o_sample_cnt} !== 48'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got ctrl=%b data=%h want all 0",
                     {o_coef_ready, o_sample_ready, o_tap_wr, o_ce, o_loaded, o_busy, o_done},
                     {o_sample, o_tap, o_sample_cnt});
        end
        n_cmp++;
        if (smp_q.size() != 0) begin
            n_err++;
            $display("FAIL midrun_pending: got %0d samples pending want 0", smp_q.size());
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int k = 0; k < 3; k++) step();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_stay_idle: got busy=%b want 0", o_busy);
        end
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_restart: got busy=%b want 1", o_busy);
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_run_gap();
        test_abort_load();
        test_continuous();
        test_start_held();
        test_reset_mid_run();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencing controller for the slow FIR datapath: on a start request it streams NTAPS coefficients from a host handshake into the filter's tap-write port, then admits input samples and issues one clock-enable per sample, spaced so the multi-cycle filter is never overrun. It sits between the host/sample source and the fixed-to-float / FIR / float-to-fixed chain, and drives the FIR's tap-write, tap and clock-enable inputs.

## Interface
- NTAPS, 16: number of coefficients written per load.
- TW, 16: coefficient and sample width.
- CE_GAP, 16: minimum cycles between successive o_ce pulses (≥1).
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset; one clock; reset is asynchronous and active-low.
- i_start  in  1  active-low start request, sampled each cycle.
- i_abort  in  1  active-high abort, returns to IDLE.
- i_nsamples  in  16  samples to process, latched at start; 0 = run until abort.
- i_coef_valid  in  1  host coefficient valid.
- i_coef  in  TW  coefficient value, tap 0 first.
- o_coef_ready  out  1  controller accepts coefficient.
- i_sample_valid  in  1  sample valid.
- i_sample  in  TW  fixed-point sample.
- o_sample_ready  out  1  controller accepts sample.
- o_sample  out  TW  registered sample, aligned with o_ce.
- o_tap_wr  out  1  FIR tap write strobe (active high).
- o_tap  out  TW  FIR tap value, aligned with o_tap_wr.
- o_ce  out  1  FIR clock enable, one cycle per sample.
- o_loaded  out  1  all NTAPS taps written since last start.
- o_busy  out  1  state ≠ IDLE.
- o_done  out  1  one-cycle pulse on completion of i_nsamples.
- o_sample_cnt  out  16  samples issued in current run.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: i_start==0 and i_abort==0 → LOAD; latch i_nsamples; clear tap index, o_loaded, o_sample_cnt.
- LOAD: o_coef_ready=1. Each handshake (i_coef_valid & o_coef_ready) increments tap index; on handshake number NTAPS → RUN, set o_loaded.
- RUN: o_sample_ready=1 only when gap counter == 0. Accept (i_sample_valid & o_sample_ready): register sample, load gap counter with CE_GAP-1, increment o_sample_cnt. When accepted count reaches latched nsamples (nonzero) → DONE after that acceptance.
- DONE: o_done=1 for one cycle → IDLE. o_loaded stays set.
- i_abort in any state → IDLE next cycle; highest priority, including over i_start in IDLE and over a final accept. Abort in LOAD leaves o_loaded=0. Pulses already registered still appear; no new ones issued.
- i_start ignored outside IDLE.
- o_sample_cnt is 16-bit, wraps at 2^16 in nsamples=0 mode without side effect.
- Gap counter decrements every cycle to 0 regardless of state; cleared on entry to LOAD.

## Timing
- Reset: state IDLE; all outputs 0 (o_coef_ready, o_sample_ready, o_sample, o_tap_wr, o_tap, o_ce, o_loaded, o_busy, o_done, o_sample_cnt).
- Coefficient handshake in cycle N → o_tap_wr=1, o_tap=coef in cycle N+1. Back-to-back handshakes give back-to-back writes; NTAPS taps take NTAPS cycles minimum.
- Start seen in cycle N → o_busy and o_coef_ready high in N+1.
- Last tap handshake in N → o_loaded=1 and RUN in N+1; first sample may be accepted in N+1.
- Sample accept in N → o_ce=1, o_sample valid in N+1; next accept no earlier than N+CE_GAP. With CE_GAP=1 one sample per cycle.
- Last sample accept in N → DONE in N+1 (o_done=1, coincident with last o_ce), IDLE in N+2.
- o_ready signals are Moore (state/counter only), never combinational on valid.

## Structure
- Package fir_ctrl_pkg: state enum (IDLE, LOAD, RUN, DONE), default TW/NTAPS/CE_GAP constants.
- Single module; no sub-module. Registers: state, tap index ($clog2(NTAPS+1)), gap counter, sample count, latched nsamples, output regs.

## Test plan
- Reset mid-RUN (i_reset low asynchronously) → all outputs 0 immediately, state IDLE; resumes only on new i_start.
- Start, stream 16 coefs 0x0001..0x0010 back-to-back → o_tap_wr high 16 consecutive cycles with o_tap 0x0001..0x0010; o_loaded rises cycle after last handshake.
- nsamples=4, CE_GAP=16, i_sample_valid held high → 4 o_ce pulses exactly 16 cycles apart, o_sample matches inputs, o_done one cycle with 4th o_ce, o_sample_cnt=4.
- Abort after 8 taps → IDLE next cycle, o_loaded=0, no further o_tap_wr; i_start+i_abort together in IDLE → stays IDLE.
- nsamples=0, CE_GAP=1 → continuous o_ce every cycle until i_abort; o_done never asserts.
- i_start held low through RUN → no reload; after o_done, held-low i_start begins new LOAD next IDLE cycle.
